instruction_fetch: RTL

IF stage of the MIPS pipeline, directly upstream of the instruction-decode stage.
- Holds the PC and the instruction memory, which the debug unit loads before execution.
- Presents the fetched instruction and PC+1 to decode, and accepts the branch target and branch-taken flag back from decode.
- Handles stall, single-step enable, branch squash and halt detection.

---
 rtl/instruction_fetch_pkg.sv | 32 +++
 rtl/instruction_fetch_memoria_instrucciones.sv | 40 ++++
 rtl/instruction_fetch.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the IF stage:
//   - state_t      : fetch FSM encoding (LOAD=0, RUN=1, HALT=2)
//   - HALT_WORD    : instruction encoding that stops fetch
//   - NOP_WORD     : encoding injected into a squashed slot
//   - clogb2()     : ceil(log2(value)), used to size memory addresses
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int LENGTH_INSTRUCTION_DEF = 32;
  localparam int CANT_BITS_ADDR_DEF     = 11;

  localparam logic [LENGTH_INSTRUCTION_DEF-1:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [LENGTH_INSTRUCTION_DEF-1:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/instruction_fetch_memoria_instrucciones.sv
// -----------------------------------------------------------------------------
// memoria_instrucciones
// Program memory for the IF stage: DEPTH x WIDTH words, one synchronous write
// port (program load) and one asynchronous read port addressed by the PC.
// Contents have no reset, so a program survives a soft reset.
//
// Ports:
//   i_clock       in   write clock
//   i_write_en    in   write strobe (already qualified by the fetch FSM)
//   i_addr_write  in   write address
//   i_data_write  in   write data
//   i_addr_read   in   read address (PC)
//   o_data_read   out  mem[i_addr_read], combinational
// -----------------------------------------------------------------------------
module memoria_instrucciones
  import instruction_fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2048,
  localparam int AW   = clogb2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_write_en,
  input  logic [AW-1:0]    i_addr_write,
  input  logic [WIDTH-1:0] i_data_write,
  input  logic [AW-1:0]    i_addr_read,
  output logic [WIDTH-1:0] o_data_read
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_write_en) begin
      r_mem[i_addr_write] <= i_data_write;
    end
  end

  assign o_data_read = r_mem[i_addr_read];

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// IF stage of the MIPS pipeline. Holds the PC and the program memory (loaded
// by the debug unit while in LOAD), presents the fetched word and PC+1 to
// decode, and takes the branch target / taken flag back from decode.
//
// Build option:
//   DELAY_SLOT_EN  defined   -> word fetched on a taken-branch edge is passed
//                               to decode unchanged (MIPS delay slot); a
//                               HALT_WORD there halts.
//                  undefined -> that word is replaced by NOP_WORD and cannot
//                               halt.
//
// Ports:
//   i_clock           in   stage clock
//   i_soft_reset      in   asynchronous reset, active-low
//   i_enable          in   debug step/run enable, 0 freezes the stage
//   i_start           in   pulse, LOAD -> RUN
//   i_stall           in   load-use stall from hazard unit
//   i_branch_control  in   branch/jump taken, from decode
//   i_branch_dir      in   branch target, from decode
//   i_write_mem       in   program-load write strobe (LOAD only)
//   i_addr_write      in   program-load address
//   i_data_write      in   program-load word
//   o_instruction     out  registered fetched instruction
//   o_out_adder_pc    out  registered PC+1 of o_instruction
//   o_pc              out  current PC
//   o_halt            out  high while in HALT
//   o_state           out  LOAD=0, RUN=1, HALT=2
//
// state   | meaning
// --------+--------------------------------------------------------------
// LOAD    | program load via i_write_mem; PC and outputs held
// RUN     | fetch one word per advance edge (enable && !stall)
// HALT    | HALT_WORD fetched; everything frozen until reset
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int LENGTH_INSTRUCTION = 32,
  parameter int CANT_BITS_ADDR     = 11,
  parameter logic [LENGTH_INSTRUCTION-1:0] HALT_WORD = instruction_fetch_pkg::HALT_WORD,
  parameter logic [LENGTH_INSTRUCTION-1:0] NOP_WORD  = instruction_fetch_pkg::NOP_WORD
) (
  input  logic                          i_clock,
  input  logic                          i_soft_reset,
  input  logic                          i_enable,
  input  logic                          i_start,
  input  logic                          i_stall,
  input  logic                          i_branch_control,
  input  logic [CANT_BITS_ADDR-1:0]     i_branch_dir,
  input  logic                          i_write_mem,
  input  logic [CANT_BITS_ADDR-1:0]     i_addr_write,
  input  logic [LENGTH_INSTRUCTION-1:0] i_data_write,
  output logic [LENGTH_INSTRUCTION-1:0] o_instruction,
  output logic [CANT_BITS_ADDR-1:0]     o_out_adder_pc,
  output logic [CANT_BITS_ADDR-1:0]     o_pc,
  output logic                          o_halt,
  output logic [1:0]                    o_state
);

  import instruction_fetch_pkg::state_t;
  import instruction_fetch_pkg::ST_LOAD;
  import instruction_fetch_pkg::ST_RUN;
  import instruction_fetch_pkg::ST_HALT;

  localparam int MEM_DEPTH = 1 << CANT_BITS_ADDR;
  localparam logic [CANT_BITS_ADDR-1:0] PC_ONE = 1;

  state_t                          r_state;
  logic [CANT_BITS_ADDR-1:0]       r_pc;
  logic [LENGTH_INSTRUCTION-1:0]   r_instruction;
  logic [CANT_BITS_ADDR-1:0]       r_adder_pc;
  logic                            r_halt;

  logic                            w_mem_write;
  logic [LENGTH_INSTRUCTION-1:0]   w_fetch;
  logic [CANT_BITS_ADDR-1:0]       w_pc_inc;
  logic                            w_advance;
  logic                            w_squash;
  logic                            w_halt_hit;

  // Program loads are only honoured in LOAD so a running program can't be
  // corrupted by a stray debug write.
  assign w_mem_write = (r_state == ST_LOAD) && i_write_mem;

  memoria_instrucciones #(
    .WIDTH (LENGTH_INSTRUCTION),
    .DEPTH (MEM_DEPTH)
  ) u_mem (
    .i_clock      (i_clock),
    .i_write_en   (w_mem_write),
    .i_addr_write (i_addr_write),
    .i_data_write (i_data_write),
    .i_addr_read  (r_pc),
    .o_data_read  (w_fetch)
  );

  // Natural wrap at 2**CANT_BITS_ADDR: the sum is truncated to the PC width.
  assign w_pc_inc  = r_pc + PC_ONE;
  assign w_advance = i_enable && !i_stall;

`ifdef DELAY_SLOT_EN
  assign w_squash = 1'b0;
`else
  assign w_squash = i_branch_control;
`endif

  // A squashed HALT_WORD never reaches decode, so it must not halt either.
  assign w_halt_hit = !w_squash && (w_fetch == HALT_WORD);

  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      r_state       <= ST_LOAD;
      r_pc          <= '0;
      r_instruction <= NOP_WORD;
      r_adder_pc    <= '0;
      r_halt        <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (i_start) begin
            r_state <= ST_RUN;
            r_pc    <= '0;
          end
        end

        ST_RUN: begin
          if (w_advance) begin
            r_adder_pc    <= w_pc_inc;
            r_instruction <= w_squash ? NOP_WORD : w_fetch;
            if (w_halt_hit) begin
              // PC parks on the HALT address for debug readout.
              r_state <= ST_HALT;
              r_halt  <= 1'b1;
            end else if (i_branch_control) begin
              r_pc <= i_branch_dir;
            end else begin
              r_pc <= w_pc_inc;
            end
          end
        end

        ST_HALT: begin
          r_halt <= 1'b1;
        end

        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  assign o_instruction  = r_instruction;
  assign o_out_adder_pc = r_adder_pc;
  assign o_pc           = r_pc;
  assign o_halt         = r_halt;
  assign o_state        = r_state;

endmodule
